// File: rtl/submdl_rotseq_pkg.sv
// Shared definitions for the rotation sequencer and its position counter.
// Build option: ROT20_CHECK_EN adds the phase-vector fault flag o_ERR.
package submdl_rotseq_pkg;

    localparam int LOOP_LEN_DEF = 2053;
    localparam int PH_LAST      = 19;
    localparam int PH_NUM       = PH_LAST + 1;
    localparam int CNT_W        = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPIN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // True when the active-low phase vector has two or more zeros.
    function automatic logic multi_zero(input logic [PH_LAST:0] vec_n);
        logic [PH_LAST:0] low;
        low = ~vec_n;
        return (low & (low - PH_NUM'(1))) != '0;
    endfunction

endpackage

// File: rtl/submdl_rotseq_poscnt.sv
// Modulo-LEN position counter with increment enable and synchronous clear.
// Also used by the page-address logic.
module submdl_rotseq_poscnt
    import submdl_rotseq_pkg::*;
#(
    parameter int LEN = LOOP_LEN_DEF,
    parameter int W   = CNT_W
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] pos_o
);

    logic [W-1:0] pos_q;
    logic [W-1:0] pos_d;

    // Next position: advance by one, wrapping LEN-1 back to zero.
    always_comb begin
        pos_d = pos_q;
        if (inc_i) begin
            pos_d = (pos_q == W'(LEN - 1)) ? '0 : pos_q + W'(1);
        end
    end

    // Position register; clear wins over increment.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/submdl_rotseq.sv
// Rotation sequencer behind the 20-phase field generator: runs the field for
// N whole rotations, tracks the loop position and emits replicate/swap strobes.
// Build option: ROT20_CHECK_EN adds the sticky phase-vector fault flag o_ERR.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | field held stopped; accepts START once the ring is empty
//   ST_SPIN  | field rotating; rem counts rotations still to complete
//   ST_DRAIN | final ph 19 passed; wait for the generator ring to empty
module submdl_rotseq
    import submdl_rotseq_pkg::*;
#(
    parameter int LOOP_LEN = LOOP_LEN_DEF,
    parameter int REPL_PH  = 4,
    parameter int SWAP_PH  = 12
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_CEN_n,
    input  logic [PH_LAST:0]  i_ROT20_n,
    input  logic              i_START,
    input  logic [CNT_W-1:0]  i_NROT,
    input  logic [CNT_W-1:0]  i_REPL_POS,
    input  logic [CNT_W-1:0]  i_SWAP_POS,
    output logic              o_STOP,
    output logic              o_READY,
    output logic              o_DONE,
    output logic [CNT_W-1:0]  o_POS,
    output logic              o_REPL_n,
`ifdef ROT20_CHECK_EN
    output logic              o_SWAP_n,
    output logic              o_ERR
`else
    output logic              o_SWAP_n
`endif
);

    state_t           state_q;
    logic [CNT_W-1:0] rem_q;
    logic             done_q;
    logic             repl_n_q;
    logic             swap_n_q;

    logic cen;
    logic empty;
    logic ph_last;
    logic pos_inc;

    assign cen     = ~i_CEN_n;
    assign empty   = &i_ROT20_n;
    assign ph_last = ~i_ROT20_n[PH_LAST];
    assign o_READY = (state_q == ST_IDLE) && empty;

    // STOP decode. In SPIN it is qualified with a non-empty ring: a one-rotation
    // run enters SPIN with rem==1 while the ring is still empty, and holding
    // STOP there would keep the generator from ever launching ph 0.
    always_comb begin
        o_STOP = 1'b1;
        case (state_q)
            ST_SPIN: o_STOP = (rem_q == CNT_W'(1)) && !empty;
            default: o_STOP = 1'b1;
        endcase
    end

    assign pos_inc = cen && (state_q == ST_SPIN) && ph_last;

    submdl_rotseq_poscnt #(
        .LEN (LOOP_LEN),
        .W   (CNT_W)
    ) u_poscnt (
        .clk_i (i_CLK),
        .clr_i (i_RST),
        .inc_i (pos_inc),
        .pos_o (o_POS)
    );

    // Run-control FSM with registered DONE and strobe outputs.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            done_q   <= 1'b0;
            repl_n_q <= 1'b1;
            swap_n_q <= 1'b1;
        end else if (cen) begin
            done_q   <= 1'b0;
            repl_n_q <= ~((state_q == ST_SPIN) && !i_ROT20_n[REPL_PH] &&
                          (o_POS == i_REPL_POS));
            swap_n_q <= ~((state_q == ST_SPIN) && !i_ROT20_n[SWAP_PH] &&
                          (o_POS == i_SWAP_POS));
            case (state_q)
                ST_IDLE: begin
                    if (i_START && o_READY) begin
                        if (i_NROT != '0) begin
                            rem_q   <= i_NROT;
                            state_q <= ST_SPIN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_SPIN: begin
                    if (ph_last) begin
                        rem_q <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (empty) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_DONE   = done_q;
    assign o_REPL_n = repl_n_q;
    assign o_SWAP_n = swap_n_q;

`ifdef ROT20_CHECK_EN
    logic err_q;

    // Sticky fault: more than one phase active on any enabled cycle.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            err_q <= 1'b0;
        end else if (cen && multi_zero(i_ROT20_n)) begin
            err_q <= 1'b1;
        end
    end

    assign o_ERR = err_q;
`endif

endmodule

// File: tb/tb_submdl_rotseq.sv
// Bench for submdl_rotseq: generator model, random CEN, scoreboard of strobe
// and DONE events predicted from loop position arithmetic.
module tb_submdl_rotseq;

    localparam int L       = 5;
    localparam int EV_REPL = 1;
    localparam int EV_SWAP = 2;
    localparam int EV_DONE = 3;

    typedef struct {
        int kind;
        int pos;
    } ev_t;

    logic        i_CLK;
    logic        i_RST;
    logic        i_CEN_n;
    logic [19:0] i_ROT20_n;
    logic        i_START;
    logic [11:0] i_NROT;
    logic [11:0] i_REPL_POS;
    logic [11:0] i_SWAP_POS;
    logic        o_STOP;
    logic        o_READY;
    logic        o_DONE;
    logic [11:0] o_POS;
    logic        o_REPL_n;
    logic        o_SWAP_n;
`ifdef ROT20_CHECK_EN
    logic        o_ERR;
`endif

    submdl_rotseq #(
        .LOOP_LEN (L),
        .REPL_PH  (4),
        .SWAP_PH  (12)
    ) dut (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_CEN_n    (i_CEN_n),
        .i_ROT20_n  (i_ROT20_n),
        .i_START    (i_START),
        .i_NROT     (i_NROT),
        .i_REPL_POS (i_REPL_POS),
        .i_SWAP_POS (i_SWAP_POS),
        .o_STOP     (o_STOP),
        .o_READY    (o_READY),
        .o_DONE     (o_DONE),
        .o_POS      (o_POS),
        .o_REPL_n   (o_REPL_n),
`ifdef ROT20_CHECK_EN
        .o_SWAP_n   (o_SWAP_n),
        .o_ERR      (o_ERR)
`else
        .o_SWAP_n   (o_SWAP_n)
`endif
    );

    int   n_cmp = 0;
    int   n_err = 0;
    ev_t  q[$];
    int   model_pos = 0;

    logic [19:0] act;
    bit          force_bad = 0;
    int          run_cnt = 0;
    int          last_run_len = 0;
    logic        stop_s;

    task automatic chk(input string nm, input int a, input int e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, a, e, $time);
        end
    endtask

    initial begin
        i_CLK = 1'b0;
        forever #5 i_CLK = ~i_CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Generator model: one-hot ring advancing on CEN, STOP honoured at ph 19
    // and while empty. Starts from an arbitrary power-up phase.
    initial begin : gen
        act       = 20'd1 << $urandom_range(0, 19);
        i_ROT20_n = ~act;
        i_CEN_n   = 1'b0;
        forever begin
            @(negedge i_CLK);
            stop_s = o_STOP;
            @(posedge i_CLK);
            if (!i_CEN_n) begin
                if (act != 20'd0) begin
                    run_cnt++;
                    if (act[19]) act = (stop_s === 1'b1) ? 20'd0 : 20'd1;
                    else act = act << 1;
                    if (act == 20'd0) begin
                        last_run_len = run_cnt;
                        run_cnt = 0;
                    end
                end else if (stop_s !== 1'b1) begin
                    act = 20'd1;
                    run_cnt = 0;
                end
            end
            #1;
            i_ROT20_n = force_bad ? 20'hFFFFC : ~act;
            i_CEN_n   = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic take(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d at pos %0d, expected none (t=%0t)",
                     kind, o_POS, $time);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_pos", int'(o_POS), e.pos);
        end
    endtask

    // Monitor: after each enabled, non-reset edge, compare any strobe/DONE.
    always begin : mon
        bit ec;
        bit er;
        @(posedge i_CLK);
        ec = !i_CEN_n;
        er = i_RST;
        @(negedge i_CLK);
        if (ec && !er) begin
            if (o_REPL_n === 1'b0) take(EV_REPL);
            if (o_SWAP_n === 1'b0) take(EV_SWAP);
            if (o_DONE === 1'b1) take(EV_DONE);
        end
    end

    task automatic launch(input int n, input int rp, input int sp);
        int k;
        int g;
        int p;
        bit pc;
        @(negedge i_CLK);
        i_REPL_POS = 12'(rp);
        i_SWAP_POS = 12'(sp);
        g = 0;
        while (!(o_READY === 1'b1 && !i_CEN_n) && g < 400) begin
            @(negedge i_CLK);
            g++;
        end
        chk("ready_before_start", int'(o_READY), 1);
        p = model_pos;
        for (int r = 0; r < n; r++) begin
            if (p == rp) q.push_back('{EV_REPL, p});
            if (p == sp) q.push_back('{EV_SWAP, p});
            p = (p + 1) % L;
        end
        q.push_back('{EV_DONE, p});
        model_pos = p;
        i_START = 1'b1;
        i_NROT  = 12'(n);
        @(negedge i_CLK);
        i_START = 1'b0;
        k = 1;
        if (n > 0) begin
            g = 0;
            while (act == 20'd0 && g < 100) begin
                pc = !i_CEN_n;
                @(negedge i_CLK);
                if (pc) k++;
                g++;
            end
            chk("start_to_ph0", k, 2);
        end
    endtask

    task automatic finish_run(input int n);
        int g;
        g = 0;
        while (q.size() != 0 && g < 40 * n + 200) begin
            @(negedge i_CLK);
            g++;
        end
        chk("run_events_left", q.size(), 0);
        q.delete();
        if (n > 0) chk("run_length", last_run_len, 20 * n);
        chk("pos_after_run", int'(o_POS), model_pos);
    endtask

    initial begin : main
        int k;
        int p0;
        int wrap_exp[3];
        wrap_exp[0] = 2;
        wrap_exp[1] = 4;
        wrap_exp[2] = 1;
        i_RST = 1'b1;
        i_START = 1'b0;
        i_NROT = '0;
        i_REPL_POS = 12'd7;
        i_SWAP_POS = 12'd7;

        // Reset from the power-up ring pattern.
        @(negedge i_CLK);
        chk("rst_stop", int'(o_STOP), 1);
        repeat (2) @(negedge i_CLK);
        chk("rst_pos", int'(o_POS), 0);
        chk("rst_done", int'(o_DONE), 0);
        chk("rst_repl", int'(o_REPL_n), 1);
        chk("rst_swap", int'(o_SWAP_n), 1);
`ifdef ROT20_CHECK_EN
        chk("rst_err", int'(o_ERR), 0);
`endif
        i_RST = 1'b0;
        k = 0;
        while (o_READY !== 1'b1 && k <= 20) begin
            if (!i_CEN_n) k++;
            @(negedge i_CLK);
        end
        chk("ready_after_rst", int'(o_READY), 1);

        // Wrap sequence with no strobe positions in range.
        for (int i = 0; i < 3; i++) begin
            launch(2, 7, 7);
            finish_run(2);
            chk("wrap_pos", int'(o_POS), wrap_exp[i]);
        end

        // One replicate strobe in rotation 2.
        launch(3, (model_pos + 1) % L, 7);
        finish_run(3);

        // Randomized runs.
        for (int i = 0; i < 20; i++) begin
            int n;
            n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            launch(n, $urandom_range(0, L), $urandom_range(0, L));
            finish_run(n);
        end

        // Reset in rotation 5 of a 10-rotation run.
        p0 = model_pos;
        launch(10, $urandom_range(0, L - 1), $urandom_range(0, L - 1));
        k = 0;
        while (!(int'(o_POS) == (p0 + 4) % L && act[7]) && k < 2000) begin
            @(negedge i_CLK);
            k++;
        end
        chk("reached_rot5", int'(act[7]), 1);
        i_RST = 1'b1;
        repeat (2) @(negedge i_CLK);
        i_RST = 1'b0;
        q.delete();
        model_pos = 0;
        chk("ready_while_ring_busy", int'(o_READY), 0);
        i_START = 1'b1;
        i_NROT  = 12'd3;
        repeat (3) @(negedge i_CLK);
        i_START = 1'b0;
        k = 0;
        while (act != 20'd0 && k <= 20) begin
            if (!i_CEN_n) k++;
            @(negedge i_CLK);
        end
        chk("ring_empty_after_rst", int'(act == 20'd0), 1);
        repeat (6) @(negedge i_CLK);
        chk("start_ignored_stop", int'(o_STOP), 1);
        chk("start_ignored_ready", int'(o_READY), 1);
        chk("pos_after_abort", int'(o_POS), 0);

        // Fresh run from position 0: replicate at pos 1, swap at pos 2.
        launch(3, 1, 2);
        finish_run(3);

`ifdef ROT20_CHECK_EN
        chk("err_clean", int'(o_ERR), 0);
        force_bad = 1;
        k = 0;
        while (k < 3) begin
            if (!i_CEN_n) k++;
            @(negedge i_CLK);
        end
        force_bad = 0;
        repeat (5) @(negedge i_CLK);
        chk("err_set", int'(o_ERR), 1);
        repeat (10) @(negedge i_CLK);
        chk("err_sticky", int'(o_ERR), 1);
        i_RST = 1'b1;
        @(negedge i_CLK);
        i_RST = 1'b0;
        @(negedge i_CLK);
        chk("err_cleared", int'(o_ERR), 0);
`endif

        repeat (10) @(negedge i_CLK);
        chk("no_stray_events", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/submdl_rotseq.md
# submdl_rotseq

Rotation sequencer placed directly downstream of the 20-phase rotating field-phase generator in the 005297 bubble controller. It consumes the active-low one-hot phase vector, counts whole field rotations, and tracks the bubble loop position modulo the loop length. It drives the generator's STOP input so the field halts after exactly N rotations. It also emits active-low replicate and swap strobes at a programmed phase and position.

## Interface
Parameters:
- LOOP_LEN, 2053: loop length in rotations; position wraps LOOP_LEN-1 -> 0.
- REPL_PH, 4: phase index (0..19) at which o_REPL_n may strobe.
- SWAP_PH, 12: phase index (0..19) at which o_SWAP_n may strobe.

Ports:
- i_CLK  in  1  single clock, all logic on posedge.
- i_RST  in  1  synchronous, active-high reset; overrides i_CEN_n.
- i_CEN_n  in  1  clock enable, active low; shared with the phase generator.
- i_ROT20_n  in  20  phase vector from the generator, active low, one-hot or all-ones (stopped).
- i_START  in  1  run request, sampled only when o_READY=1.
- i_NROT  in  12  rotation count, latched with i_START.
- i_REPL_POS  in  12  loop position for the replicate strobe.
- i_SWAP_POS  in  12  loop position for the swap strobe.
- o_STOP  out  1  to the generator's STOP input.
- o_READY  out  1  idle and field stopped.
- o_DONE  out  1  one-CEN-cycle pulse at run end.
- o_POS  out  12  current loop position.
- o_REPL_n  out  1  replicate strobe, active low.
- o_SWAP_n  out  1  swap strobe, active low.
- o_ERR  out  1  phase-vector fault; present only with the macro in Configuration.

## Operation
- "ph k" means i_ROT20_n[k]==0. "Empty" means i_ROT20_n is all ones.
- State registers advance only on cycles with ~i_CEN_n. i_RST acts on any cycle.
- States:
  - IDLE: o_STOP=1. o_READY = empty.
  - SPIN: o_STOP = (rem==1).
  - DRAIN: o_STOP=1.
- IDLE:
  - i_START & o_READY & i_NROT!=0: latch rem=i_NROT, go to SPIN.
  - i_START & o_READY & i_NROT==0: o_DONE pulse, stay in IDLE.
  - i_START while o_READY=0: ignored.
- SPIN, on each ph 19:
  - rem decrements.
  - o_POS increments, with wrap at LOOP_LEN-1 -> 0.
  - If rem was 1, go to DRAIN.
- DRAIN: go to IDLE on the first empty vector, with an o_DONE pulse.
- o_REPL_n is low only when all hold: SPIN, ph REPL_PH, o_POS==i_REPL_POS.
- o_SWAP_n is low only when all hold: SPIN, ph SWAP_PH, o_POS==i_SWAP_POS.
- o_POS persists across runs. It clears only on reset.
- rem is 12-bit unsigned. o_POS never reaches LOOP_LEN.
- Reset values: state IDLE, o_STOP=1, o_READY=0, o_DONE=0, o_POS=0, o_REPL_n=1, o_SWAP_n=1, o_ERR=0, rem=0.
- Reset mid-run: aborts the run with no o_DONE. Because o_STOP=1, the generator empties within 20 CEN cycles, after which o_READY=1.

## Timing
- All outputs are registered, except o_STOP and o_READY, which decode registered state and the input vector.
- o_STOP=1 is presented during the CEN cycle in which ph 19 of the final rotation is active. The generator therefore loads all-zero: the ring empties exactly at the end of rotation N.
- START to first ph 0: 2 CEN cycles. The SPIN transition is registered, then the generator sets bit 0 on the next CEN.
- Run length from first ph 0 to empty: 20*N CEN cycles. o_DONE fires 1 CEN after empty is observed.
- Strobes: each asserts 1 CEN after its phase is active and lasts exactly 1 CEN cycle.
- CEN gaps: state, counters and outputs hold.

## Configuration
- ROT20_CHECK_EN defined: o_ERR is a sticky flag. It sets on any CEN cycle where i_ROT20_n has two or more zeros, and clears only on i_RST.
- ROT20_CHECK_EN undefined: the checker logic and the o_ERR port are absent.

## Structure
- Shared include file holds:
  - state encodings ST_IDLE, ST_SPIN, ST_DRAIN;
  - the LOOP_LEN default;
  - constant PH_LAST=19.
- One sub-module, submdl_rotseq_poscnt: the mod-LOOP_LEN position counter with increment-enable and sync clear. It is reusable by the page-address logic.

## Test plan
- Reset with the generator at its power-up pattern: o_STOP=1 at once; o_READY=1 within 20 CEN cycles; o_POS=0.
- i_NROT=3, start from empty: exactly 60 CEN cycles of one-hot phases, then empty; one o_DONE pulse; o_POS=3.
- LOOP_LEN=5, three runs of i_NROT=2: o_POS goes 2 -> 4 -> 1 (wrap verified).
- i_REPL_POS=1, i_NROT=3: exactly one o_REPL_n low, during rotation 2 at ph 4. No strobes in IDLE or DRAIN.
- i_RST asserted mid-rotation 5 of a 10-rotation run: no o_DONE; ring empties within 20 CEN; a START issued before empty is ignored.
- ROT20_CHECK_EN defined, force i_ROT20_n=20'hFFFFC: o_ERR=1 and it stays set until i_RST.
